// File: rtl/fetch_unit_if.sv
// Fetch-stage signal bundle: instruction-memory port, hazard-unit controls,
// redirect input and the fetch/decode latch outputs.
interface fetch_unit_if;
    logic        ihit;
    logic [31:0] imemload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        pcEN;
    logic        fdEN;
    logic        fd_flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] fd_instr;
    logic [31:0] fd_npc;
    logic        fd_valid;
    logic [31:0] pc;
    logic        fetch_halted;

    modport master (
        input  ihit, imemload, pcEN, fdEN, fd_flush, redirect, redirect_pc,
        output imemREN, imemaddr, fd_instr, fd_npc, fd_valid, pc, fetch_halted
    );

    modport slave (
        output ihit, imemload, pcEN, fdEN, fd_flush, redirect, redirect_pc,
        input  imemREN, imemaddr, fd_instr, fd_npc, fd_valid, pc, fetch_halted
    );
endinterface

// File: rtl/fetch_unit.sv
// MIPS instruction fetch stage: owns the PC, fills the fetch/decode latch,
// defers redirects that land during an outstanding access, and stops on HALT.
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP = 6'b111111
) (
    input  logic          CLK,
    input  logic          RST,
    fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {RUN, REDIR_WAIT, HALTED} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pending_q, pending_d;
    logic [31:0] fd_instr_q, fd_instr_d;
    logic [31:0] fd_npc_q, fd_npc_d;
    logic        fd_valid_q, fd_valid_d;
    logic        halted_q, halted_d;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pending_d  = pending_q;
        fd_instr_d = fd_instr_q;
        fd_npc_d   = fd_npc_q;
        fd_valid_d = fd_valid_q;
        halted_d   = halted_q;

        case (state_q)
            RUN: begin
                if (bus.redirect) begin
                    fd_instr_d = '0;
                    fd_npc_d   = '0;
                    fd_valid_d = 1'b0;
                    // A miss keeps imemaddr stable, so the target waits in pending.
                    if (bus.ihit) begin
                        pc_d = bus.redirect_pc;
                    end else begin
                        pending_d = bus.redirect_pc;
                        state_d   = REDIR_WAIT;
                    end
                end else begin
                    if (bus.ihit && bus.pcEN) begin
                        pc_d = pc_plus4;
                    end
                    if (bus.fd_flush) begin
                        fd_instr_d = '0;
                        fd_npc_d   = '0;
                        fd_valid_d = 1'b0;
                    end else if (bus.fdEN && bus.ihit) begin
                        fd_instr_d = bus.imemload;
                        fd_npc_d   = pc_plus4;
                        fd_valid_d = 1'b1;
                    end else if (bus.fdEN) begin
                        fd_instr_d = '0;
                        fd_npc_d   = '0;
                        fd_valid_d = 1'b0;
                    end
                    if (bus.ihit && bus.pcEN && bus.fdEN && !bus.fd_flush &&
                        bus.imemload[31:26] == HALT_OP) begin
                        state_d  = HALTED;
                        halted_d = 1'b1;
                    end
                end
            end

            REDIR_WAIT: begin
                if (bus.redirect) begin
                    pending_d = bus.redirect_pc;
                end
                // The word returned here belongs to the squashed path and is dropped.
                if (bus.ihit) begin
                    pc_d    = bus.redirect ? bus.redirect_pc : pending_q;
                    state_d = RUN;
                end
            end

            HALTED: begin
                if (bus.redirect) begin
                    pc_d       = bus.redirect_pc;
                    fd_instr_d = '0;
                    fd_npc_d   = '0;
                    fd_valid_d = 1'b0;
                    halted_d   = 1'b0;
                    state_d    = RUN;
                end else if (bus.fd_flush) begin
                    fd_instr_d = '0;
                    fd_npc_d   = '0;
                    fd_valid_d = 1'b0;
                end
            end

            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= RUN;
            pc_q       <= PC_INIT;
            pending_q  <= '0;
            fd_instr_q <= '0;
            fd_npc_q   <= '0;
            fd_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pending_q  <= pending_d;
            fd_instr_q <= fd_instr_d;
            fd_npc_q   <= fd_npc_d;
            fd_valid_q <= fd_valid_d;
            halted_q   <= halted_d;
        end
    end

    assign bus.imemREN      = !RST && (state_q != HALTED);
    assign bus.imemaddr     = pc_q;
    assign bus.pc           = pc_q;
    assign bus.fd_instr     = fd_instr_q;
    assign bus.fd_npc       = fd_npc_q;
    assign bus.fd_valid     = fd_valid_q;
    assign bus.fetch_halted = halted_q;

endmodule
